// File: rtl/rename_stage.sv
// Multi-lane register-rename stage: allocates physical destinations, maps sources through
// a speculative RAT with in-group forwarding, tracks ready bits, recycles on commit, restores on flush.
module rename_stage #(
  parameter int WIDTH        = 4,
  parameter int ARCH_REGS    = 10,
  parameter int PHYS_REGS    = 32,
  parameter int ROB_DEPTH    = 32,
  parameter int CMPLT_PORTS  = 6,
  parameter int COMMIT_PORTS = 4,
  localparam int ARCH_W = 4,
  localparam int PR_W   = $clog2(PHYS_REGS),
  localparam int ROB_W  = $clog2(ROB_DEPTH),
  localparam int OUT_W  = 4 + 4*PR_W + 2 + 4 + ROB_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [24*WIDTH-1:0]            in_ops,
  input  logic [WIDTH-1:0]               in_valid,
  output logic [WIDTH-1:0]               in_ready,
  input  logic [ROB_W-1:0]               rob_tail,
  input  logic [ROB_W:0]                 rob_free,
  input  logic [CMPLT_PORTS-1:0]         cmplt_valid,
  input  logic [PR_W*CMPLT_PORTS-1:0]    cmplt_pr,
  input  logic [COMMIT_PORTS-1:0]        commit_valid,
  input  logic [ARCH_W*COMMIT_PORTS-1:0] commit_arch,
  input  logic [PR_W*COMMIT_PORTS-1:0]   commit_pr,
  input  logic [PR_W*COMMIT_PORTS-1:0]   commit_old_pr,
  input  logic                           flush,
  output logic [WIDTH-1:0]               out_valid,
  output logic [OUT_W*WIDTH-1:0]         out_ops,
  input  logic                           out_ready
);

  localparam logic [ARCH_W-1:0] ARCH_LAST = ARCH_W'(ARCH_REGS - 1);

  logic [PR_W-1:0]      spec_rat [ARCH_REGS];
  logic [PR_W-1:0]      cmt_rat  [ARCH_REGS];
  logic [PR_W-1:0]      rat_nxt  [ARCH_REGS];
  logic [PR_W-1:0]      cmt_nxt  [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_vec, ready_vec;
  logic [PHYS_REGS-1:0] alloc_mask, cmplt_mask, commit_free_mask, mapped_mask;
  logic [OUT_W*WIDTH-1:0] ops_nxt;
  logic                 load, chain, pick_ok, s0_rdy, s1_rdy;
  logic [PR_W-1:0]      pick, s0_pr, s1_pr, old_pr, dst_pr;
  logic [23:0]          op;
  logic [ARCH_W-1:0]    dst_a, s0_a, s1_a;
  logic [(1<<ARCH_W)-1:0] written;
  logic [ROB_W-1:0]     rob_idx;
  logic [WIDTH-1:0]     unused_rsvd;

  // Handshake: in_ready[i] means lane i is consumed this cycle (prefix of in_valid);
  // out_valid is a registered group that downstream takes whole when out_ready is high.
  assign load = !flush && (out_valid == '0 || out_ready);

  always_comb begin
    cmplt_mask = '0;
    for (int p = 0; p < CMPLT_PORTS; p++)
      if (cmplt_valid[p]) cmplt_mask[cmplt_pr[p*PR_W +: PR_W]] = 1'b1;
  end

  // Commits apply in ascending port order so a later port wins on the same arch reg.
  always_comb begin
    cmt_nxt          = cmt_rat;
    commit_free_mask = '0;
    mapped_mask      = '0;
    for (int p = 0; p < COMMIT_PORTS; p++) begin
      if (commit_valid[p]) begin
        if (commit_arch[p*ARCH_W +: ARCH_W] <= ARCH_LAST)
          cmt_nxt[commit_arch[p*ARCH_W +: ARCH_W]] = commit_pr[p*PR_W +: PR_W];
        commit_free_mask[commit_old_pr[p*PR_W +: PR_W]] = 1'b1;
      end
    end
    for (int a = 0; a < ARCH_REGS; a++) mapped_mask[cmt_nxt[a]] = 1'b1;
  end

  always_comb begin
    rat_nxt     = spec_rat;
    alloc_mask  = '0;
    written     = '0;
    in_ready    = '0;
    ops_nxt     = '0;
    unused_rsvd = '0;
    chain       = load;
    op = '0; dst_a = '0; s0_a = '0; s1_a = '0;
    pick = '0; pick_ok = 1'b0; s0_pr = '0; s1_pr = '0; old_pr = '0; dst_pr = '0;
    s0_rdy = 1'b0; s1_rdy = 1'b0; rob_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op             = in_ops[i*24 +: 24];
      unused_rsvd[i] = op[0];
      dst_a = op[19:16];
      s0_a  = op[15:12];
      s1_a  = op[11:8];
      // Descending scan so the last hit is the lowest-index free reg not yet taken.
      pick_ok = 1'b0;
      pick    = '0;
      for (int r = PHYS_REGS-1; r >= 0; r--) begin
        if (free_vec[r] && !alloc_mask[r]) begin
          pick_ok = 1'b1;
          pick    = PR_W'(r);
        end
      end
      chain = chain && in_valid[i] && ((ROB_W+1)'(i+1) <= rob_free) && (!op[3] || pick_ok);
      if (chain) begin
        in_ready[i] = 1'b1;
        s0_pr  = (s0_a <= ARCH_LAST) ? rat_nxt[s0_a] : '0;
        s1_pr  = (s1_a <= ARCH_LAST) ? rat_nxt[s1_a] : '0;
        old_pr = (dst_a <= ARCH_LAST) ? rat_nxt[dst_a] : '0;
        s0_rdy = !op[2] || (!written[s0_a] && (ready_vec[s0_pr] || cmplt_mask[s0_pr]));
        s1_rdy = !op[1] || (!written[s1_a] && (ready_vec[s1_pr] || cmplt_mask[s1_pr]));
        dst_pr  = op[3] ? pick : '0;
        rob_idx = rob_tail + ROB_W'(i);
        if (op[3]) begin
          alloc_mask[pick] = 1'b1;
          written[dst_a]   = 1'b1;
          if (dst_a <= ARCH_LAST) rat_nxt[dst_a] = pick;
        end
        ops_nxt[i*OUT_W +: OUT_W] = {op[23:20], dst_pr, s0_pr, s1_pr, old_pr,
                                     s0_rdy, s1_rdy, op[7:4], rob_idx, op[3]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < ARCH_REGS; a++) begin
        spec_rat[a] <= PR_W'(a);
        cmt_rat[a]  <= PR_W'(a);
      end
      for (int r = 0; r < PHYS_REGS; r++) free_vec[r] <= (r >= ARCH_REGS);
      ready_vec <= '1;
      out_valid <= '0;
      out_ops   <= '0;
    end else begin
      cmt_rat <= cmt_nxt;
      if (flush) begin
        spec_rat  <= cmt_nxt;
        free_vec  <= ~mapped_mask;
        ready_vec <= ready_vec | mapped_mask | cmplt_mask;
        out_valid <= '0;
      end else begin
        spec_rat  <= rat_nxt;
        free_vec  <= (free_vec & ~alloc_mask) | commit_free_mask;
        ready_vec <= (ready_vec & ~alloc_mask) | cmplt_mask;
        if (load) begin
          out_valid <= in_ready;
          out_ops   <= ops_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: expected renamed lanes are queued when a group is
// driven and checked against the registered output one cycle later.
module tb_rename_stage;
  localparam int OUT_W = 36;

  logic         clk, rst, flush, out_ready;
  logic [95:0]  in_ops;
  logic [3:0]   in_valid, in_ready, out_valid;
  logic [4:0]   rob_tail;
  logic [5:0]   rob_free;
  logic [5:0]   cmplt_valid;
  logic [29:0]  cmplt_pr;
  logic [3:0]   commit_valid;
  logic [15:0]  commit_arch;
  logic [19:0]  commit_pr, commit_old_pr;
  logic [143:0] out_ops;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  rename_stage dut (
    .clk(clk), .rst(rst), .in_ops(in_ops), .in_valid(in_valid), .in_ready(in_ready),
    .rob_tail(rob_tail), .rob_free(rob_free), .cmplt_valid(cmplt_valid), .cmplt_pr(cmplt_pr),
    .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_pr(commit_pr),
    .commit_old_pr(commit_old_pr), .flush(flush), .out_valid(out_valid), .out_ops(out_ops),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] mk_op(input logic [3:0] opc, dst, s0, s1, imm,
                                        input logic de, s0e, s1e);
    return {opc, dst, s0, s1, imm, de, s0e, s1e, 1'b0};
  endfunction

  function automatic logic [OUT_W-1:0] ex(input logic [3:0] opc, input logic [4:0] dpr, s0, s1, old,
                                          input logic r0, r1, input logic [3:0] imm,
                                          input logic [4:0] rob, input logic de);
    return {opc, dpr, s0, s1, old, r0, r1, imm, rob, de};
  endfunction

  function automatic logic [4:0] next_free_after_flush(input logic [4:0] pr);
    logic [4:0] n;
    n = pr + 5'd1;
    if (n == 5'd15) n = 5'd16;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_lane(input int i, input logic [23:0] lane_op);
    in_ops[i*24 +: 24] = lane_op;
  endtask

  task automatic push_exp(input logic [OUT_W-1:0] e);
    exp_q.push_back(e);
  endtask

  // Check in_ready for the driven group, then clock it in and clear one-shot inputs.
  task automatic cycle(input logic [3:0] exp_rdy, input string tag);
    #1;
    chk({tag, ".in_ready"}, in_ready, exp_rdy);
    @(posedge clk);
    #1;
    in_valid     = '0;
    cmplt_valid  = '0;
    commit_valid = '0;
    flush        = 1'b0;
  endtask

  task automatic check_out(input logic [3:0] exp_v, input string tag);
    logic [OUT_W-1:0] e;
    chk({tag, ".out_valid"}, out_valid, exp_v);
    for (int i = 0; i < 4; i++) begin
      if (exp_v[i]) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL %s.lane%0d observed=out_valid expected=queued entry", tag, i);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("%s.lane%0d", tag, i), out_ops[i*OUT_W +: OUT_W], e);
        end
      end
    end
  endtask

  initial begin
    logic [4:0] pr, old, rob;
    logic [3:0] mask, immv;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_ops = '0; in_valid = '0; rob_tail = '0; rob_free = 6'd32;
    cmplt_valid = '0; cmplt_pr = '0;
    commit_valid = '0; commit_arch = '0; commit_pr = '0; commit_old_pr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.out_valid", out_valid, 4'b0000);
    chk("reset.in_ready", in_ready, 4'b0000);

    // Four writers of arch 0..3 with in-group source forwarding.
    rob_tail = 5'd0;
    set_lane(0, mk_op(1, 0, 5, 6, 1, 1, 1, 1));
    set_lane(1, mk_op(2, 1, 0, 7, 2, 1, 1, 0));
    set_lane(2, mk_op(3, 2, 1, 9, 3, 1, 1, 1));
    set_lane(3, mk_op(4, 3, 3, 2, 4, 1, 1, 1));
    in_valid = 4'b1111;
    push_exp(ex(1, 10, 5, 6, 0, 1, 1, 1, 0, 1));
    push_exp(ex(2, 11, 10, 7, 1, 0, 1, 2, 1, 1));
    push_exp(ex(3, 12, 11, 9, 2, 0, 1, 3, 2, 1));
    push_exp(ex(4, 13, 3, 12, 3, 1, 0, 4, 3, 1));
    cycle(4'b1111, "first");
    check_out(4'b1111, "first");

    // Completion of pr 12 in the same cycle is bypassed into src0_rdy.
    rob_tail = 5'd4;
    cmplt_valid = 6'b000100;
    cmplt_pr[10 +: 5] = 5'd12;
    set_lane(0, mk_op(5, 9, 2, 3, 5, 0, 1, 1));
    in_valid = 4'b0001;
    push_exp(ex(5, 0, 12, 13, 9, 1, 0, 5, 4, 0));
    cycle(4'b0001, "bypass");
    check_out(4'b0001, "bypass");

    // Lane1 reads arch 2 written by lane0; pr 12 now latched ready.
    rob_tail = 5'd5;
    set_lane(0, mk_op(6, 2, 4, 2, 6, 1, 1, 1));
    set_lane(1, mk_op(7, 5, 2, 1, 7, 1, 1, 1));
    in_valid = 4'b0011;
    push_exp(ex(6, 14, 4, 12, 12, 1, 1, 6, 5, 1));
    push_exp(ex(7, 15, 14, 11, 5, 0, 0, 7, 6, 1));
    cycle(4'b0011, "fwd");
    check_out(4'b0011, "fwd");

    // Only two ROB entries free; rob_idx wraps 31 -> 0.
    rob_tail = 5'd31;
    rob_free = 6'd2;
    set_lane(0, mk_op(8, 6, 5, 0, 8, 1, 1, 0));
    set_lane(1, mk_op(9, 6, 6, 0, 9, 1, 1, 0));
    set_lane(2, mk_op(10, 7, 0, 0, 10, 1, 0, 0));
    set_lane(3, mk_op(11, 8, 0, 0, 11, 1, 0, 0));
    in_valid = 4'b1111;
    push_exp(ex(8, 16, 15, 10, 6, 0, 1, 8, 31, 1));
    push_exp(ex(9, 17, 16, 10, 16, 0, 1, 9, 0, 1));
    cycle(4'b0011, "robfree");
    check_out(4'b0011, "robfree");
    rob_free = 6'd32;

    // Thirteen more allocations (21 in total) leave one free register.
    rob = 5'd1; pr = 5'd18; old = 5'd7;
    for (int g = 0; g < 4; g++) begin
      mask = (g < 3) ? 4'b1111 : 4'b0001;
      rob_tail = rob;
      for (int i = 0; i < 4; i++) set_lane(i, mk_op(12, 7, 0, 0, 0, 1, 0, 0));
      in_valid = mask;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          push_exp(ex(12, pr, 10, 10, old, 1, 1, 0, rob, 1));
          old = pr; pr = pr + 5'd1; rob = rob + 5'd1;
        end
      end
      cycle(mask, $sformatf("fill%0d", g));
      check_out(mask, $sformatf("fill%0d", g));
    end

    // One free reg; a commit frees pr 5 but only for the next cycle.
    rob_tail = 5'd14;
    for (int i = 0; i < 4; i++) set_lane(i, mk_op(13, 8, 0, 0, 0, 1, 0, 0));
    in_valid = 4'b1111;
    commit_valid = 4'b0001;
    commit_arch[3:0] = 4'd5; commit_pr[4:0] = 5'd15; commit_old_pr[4:0] = 5'd5;
    push_exp(ex(13, 31, 10, 10, 8, 1, 1, 0, 14, 1));
    cycle(4'b0001, "lastfree");
    check_out(4'b0001, "lastfree");

    rob_tail = 5'd15;
    in_valid = 4'b1111;
    push_exp(ex(13, 5, 10, 10, 31, 1, 1, 0, 15, 1));
    cycle(4'b0001, "recycled");
    check_out(4'b0001, "recycled");

    // Free list empty: dst_en=0 lanes in the prefix still pass.
    rob_tail = 5'd16;
    set_lane(0, mk_op(14, 0, 1, 0, 0, 0, 1, 0));
    set_lane(1, mk_op(14, 0, 0, 0, 1, 0, 0, 0));
    set_lane(2, mk_op(14, 3, 0, 0, 2, 1, 0, 0));
    set_lane(3, mk_op(14, 0, 0, 0, 3, 0, 0, 0));
    in_valid = 4'b1111;
    push_exp(ex(14, 0, 11, 10, 10, 0, 1, 0, 16, 0));
    push_exp(ex(14, 0, 10, 10, 10, 1, 1, 1, 17, 0));
    cycle(4'b0011, "empty");
    check_out(4'b0011, "empty");

    // Downstream stalls: nothing accepted, output held.
    out_ready = 1'b0;
    set_lane(0, mk_op(14, 0, 0, 0, 4, 0, 0, 0));
    in_valid = 4'b0001;
    cycle(4'b0000, "hold");
    chk("hold.out_valid", out_valid, 4'b0011);
    chk("hold.lane0", out_ops[35:0], ex(14, 0, 11, 10, 10, 0, 1, 0, 16, 0));

    // Flush with a same-cycle commit of arch 0 -> pr 10.
    out_ready = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 4; i++) set_lane(i, mk_op(3, 0, 0, 0, 0, 1, 0, 0));
    in_valid = 4'b1111;
    commit_valid = 4'b0010;
    commit_arch[7:4] = 4'd0; commit_pr[9:5] = 5'd10; commit_old_pr[9:5] = 5'd0;
    cycle(4'b0000, "flush");
    check_out(4'b0000, "flush");

    // Restored mapping: arch0 -> 10, arch5 -> 15, others identity; free = 22 regs.
    rob_tail = 5'd0;
    set_lane(0, mk_op(15, 1, 0, 5, 0, 1, 1, 1));
    set_lane(1, mk_op(15, 2, 1, 2, 1, 1, 1, 1));
    set_lane(2, mk_op(15, 3, 6, 7, 2, 1, 0, 0));
    set_lane(3, mk_op(15, 4, 6, 7, 3, 1, 0, 0));
    in_valid = 4'b1111;
    push_exp(ex(15, 0, 10, 15, 1, 1, 1, 0, 0, 1));
    push_exp(ex(15, 5, 0, 2, 2, 0, 1, 1, 1, 1));
    push_exp(ex(15, 11, 6, 7, 3, 1, 1, 2, 2, 1));
    push_exp(ex(15, 12, 6, 7, 4, 1, 1, 3, 3, 1));
    cycle(4'b1111, "restored");
    check_out(4'b1111, "restored");

    // Drain the remaining 18 free regs, then confirm the list is empty.
    rob = 5'd4; pr = 5'd13; old = 5'd9;
    for (int g = 0; g < 6; g++) begin
      mask = (g < 4) ? 4'b1111 : ((g == 4) ? 4'b0011 : 4'b0000);
      rob_tail = rob;
      immv = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) set_lane(i, mk_op(0, 9, 0, 0, immv, 1, 0, 0));
      in_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          push_exp(ex(0, pr, 10, 10, old, 1, 1, immv, rob, 1));
          old = pr; pr = next_free_after_flush(pr); rob = rob + 5'd1;
        end
      end
      cycle(mask, $sformatf("drain%0d", g));
      check_out(mask, $sformatf("drain%0d", g));
    end

    // Reset while a group is pending drops it and restores the initial mapping.
    rob_tail = 5'd0;
    set_lane(0, mk_op(1, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 4'b0001;
    push_exp(ex(1, 0, 10, 10, 10, 1, 1, 0, 0, 0));
    cycle(4'b0001, "prerst");
    check_out(4'b0001, "prerst");

    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = 4'b0001;
    cycle(4'b0000, "midrst");
    rst = 1'b0;
    chk("midrst.out_valid", out_valid, 4'b0000);

    out_ready = 1'b1;
    set_lane(0, mk_op(2, 0, 1, 0, 0, 1, 1, 0));
    in_valid = 4'b0001;
    push_exp(ex(2, 10, 1, 0, 0, 1, 1, 0, 0, 1));
    cycle(4'b0001, "postrst");
    check_out(4'b0001, "postrst");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
# rename_stage

Parametrised multi-lane register-rename stage between the micro-op decoder and the reservation stations/ROB. Each cycle it renames an in-order group of up to WIDTH micro-ops: it allocates physical destinations from a free list, maps sources through a speculative RAT with intra-group forwarding, and tags each op with a ROB index and physical-ready bits. It also tracks per-physical-register ready state from completion ports, recycles registers from commit ports, and restores the committed mapping on flush.

## Interface
- WIDTH, 4, lanes per group
- ARCH_REGS, 10, architectural registers; arch index width ARCH_W = 4
- PHYS_REGS, 32, physical registers; PR_W = clog2(PHYS_REGS)
- ROB_DEPTH, 32, ROB entries; ROB_W = clog2(ROB_DEPTH)
- CMPLT_PORTS, 6, completion wakeup ports
- COMMIT_PORTS, 4, commit/free ports
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_ops  in  24*WIDTH  lane i op: [23:20] opcode, [19:16] dst arch, [15:12] src0 arch, [11:8] src1 arch, [7:4] imm, [3] dst_en, [2] src0_en, [1] src1_en, [0] reserved
- in_valid  in  WIDTH  lane valids, contiguous from lane 0
- in_ready  out  WIDTH  lane i consumed this cycle (always a prefix)
- rob_tail  in  ROB_W  next free ROB index
- rob_free  in  ROB_W+1  free ROB entries
- cmplt_valid / cmplt_pr  in  CMPLT_PORTS / PR_W*CMPLT_PORTS  physical regs written back
- commit_valid / commit_arch / commit_pr / commit_old_pr  in  COMMIT_PORTS / ARCH_W*, PR_W*, PR_W* per port  retiring ops: new mapping and reg to free
- flush  in  1  restore committed state
- out_valid  out  WIDTH  registered renamed lanes
- out_ops  out  (4+4*PR_W+2+4+ROB_W+1)*WIDTH  per lane {opcode, dst_pr, src0_pr, src1_pr, old_pr, src0_rdy, src1_rdy, imm, rob_idx, dst_en}
- out_ready  in  1  downstream takes the whole output group

## Operation
- State: spec RAT and committed RAT (ARCH_REGS x PR_W), free vector (PHYS_REGS bits), ready vector (PHYS_REGS bits), output register.
- Reset: both RATs identity (arch r -> phys r); free = regs ARCH_REGS..PHYS_REGS-1; ready all 1; out_valid 0; in_ready 0.
- Load condition L = !flush && (out_valid == 0 || out_ready).
- Acceptance: lane i accepted iff L, in_valid[i], lanes 0..i-1 accepted, enough free regs for dst_en lanes 0..i (lowest-index-first allocation), and i+1 <= rob_free. Stop at first failure.
- Lane i: dst_pr = allocated reg if dst_en, else 0; old_pr = RAT[dst] after updates by lanes <i; src_pr = RAT[src] after lanes <i (intra-group forwarding, youngest earlier writer wins). rob_idx = (rob_tail+i) mod ROB_DEPTH.
- srcN_rdy = !srcN_en || (src not produced by an earlier lane in the group && (ready[src_pr] || src_pr hit on any cmplt port this cycle)).
- Update: spec RAT gets final mapping; allocated regs cleared from free and ready.
- Output register: on L, out_valid <= in_ready, out_ops loaded; else held. Unaccepted lanes hold 0 valid.
- Completion: ready[cmplt_pr] <= 1, every cycle including flush. Ops held in the output register are not re-woken (RS snoops).
- Commit: committed RAT[commit_arch] <= commit_pr (ports in ascending order, later wins); free[commit_old_pr] <= 1.
- Flush: spec RAT <= committed RAT after this cycle's commits; free <= every reg not in that RAT; ready <= 1 for those mapped regs; out_valid <= 0; in_ready 0.

## Timing
- Input -> output latency 1 cycle; in_ready is combinational from state, in_valid, rob_free, out_ready, flush.
- Freed reg is allocatable from the cycle after commit, never same cycle.
- Completion same cycle as rename is bypassed into src_rdy.
- Flush beats rename and commit frees; its restored state is visible next cycle.
- rst mid-group: all state returns to reset values next cycle, pending output dropped.
- Free list empty: lanes with dst_en stall; dst_en=0 lanes still pass if in prefix.
- rob_free=0: in_ready all 0.

## Test plan
- After reset, 4 ops writing arch 0,1,2,3 -> dst_pr 10,11,12,13, old_pr 0,1,2,3, out_valid 4'b1111 next cycle.
- Group: lane0 writes arch 2, lane1 reads arch 2 -> lane1 src0_pr = lane0 dst_pr, src0_rdy 0.
- 21 allocations then 4-op group with 1 free reg and dst_en all 1 -> in_ready 4'b0001; commit freeing reg 5 -> next cycle lane gets pr 5.
- rob_free=2 with 4 valid ops -> in_ready 4'b0011, rob_idx tail, tail+1 wrapping 31->0.
- Rename src mapped to pr 12 while cmplt_pr=12 same cycle -> src_rdy 1.
- Rename 3 groups, commit 1 op, flush -> spec RAT equals committed RAT, free count = PHYS_REGS-ARCH_REGS, out_valid 0.
